// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the MEM pipeline stage: aluop codes of the memory
// instructions, stall/write-enable constants, bus widths and the FSM state
// encoding. Also provides a helper that classifies an aluop as a memory op.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int SEL_W      = 4;
    localparam int ALUOP_W    = 8;

    localparam logic STOP          = 1'b1;
    localparam logic NO_STOP       = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [DATA_W-1:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // True for every aluop that needs a data-bus transaction.
    function automatic logic is_mem_op(input logic [ALUOP_W-1:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_mem_op = 1'b1;
            default:                         is_mem_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lane.sv
// -----------------------------------------------------------------------------
// mem_lane
// Combinational byte-lane logic for the MEM stage (big-endian lane order).
//   aluop_i    : operation code
//   addr_lo_i  : low two address bits
//   store_i    : store data (reg2)
//   rdata_i    : captured bus read data
//   sel_o      : byte selects for the bus
//   wdata_o    : store data replicated onto the selected lanes
//   load_o     : sign/zero extended load result
//   is_load_o / is_store_o : operation class
// Halfword accesses use addr[1] only and word accesses ignore addr[1:0].
// -----------------------------------------------------------------------------
import mem_stage_pkg::*;

module mem_lane (
    input  logic [7:0]  aluop_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o,
    output logic        is_load_o,
    output logic        is_store_o
);

    logic [3:0]  w_byte_sel;
    logic [3:0]  w_half_sel;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte lane; lane 0 is the most significant byte.
    always_comb begin
        case (addr_lo_i)
            2'b00:   begin w_byte_sel = 4'b1000; w_byte = rdata_i[31:24]; end
            2'b01:   begin w_byte_sel = 4'b0100; w_byte = rdata_i[23:16]; end
            2'b10:   begin w_byte_sel = 4'b0010; w_byte = rdata_i[15:8];  end
            2'b11:   begin w_byte_sel = 4'b0001; w_byte = rdata_i[7:0];   end
            default: begin w_byte_sel = 4'b0000; w_byte = 8'h00;          end
        endcase
    end

    // Halfword lane chosen by addr[1] alone.
    always_comb begin
        if (addr_lo_i[1]) begin
            w_half_sel = 4'b0011;
            w_half     = rdata_i[15:0];
        end else begin
            w_half_sel = 4'b1100;
            w_half     = rdata_i[31:16];
        end
    end

    // Per-opcode selects, store replication and load extension.
    always_comb begin
        sel_o      = 4'b0000;
        wdata_o    = store_i;
        load_o     = ZERO_WORD;
        is_load_o  = 1'b0;
        is_store_o = 1'b0;
        case (aluop_i)
            EXE_LB_OP:  begin is_load_o = 1'b1; sel_o = w_byte_sel; load_o = {{24{w_byte[7]}}, w_byte}; end
            EXE_LBU_OP: begin is_load_o = 1'b1; sel_o = w_byte_sel; load_o = {24'h000000, w_byte}; end
            EXE_LH_OP:  begin is_load_o = 1'b1; sel_o = w_half_sel; load_o = {{16{w_half[15]}}, w_half}; end
            EXE_LHU_OP: begin is_load_o = 1'b1; sel_o = w_half_sel; load_o = {16'h0000, w_half}; end
            EXE_LW_OP:  begin is_load_o = 1'b1; sel_o = 4'b1111;    load_o = rdata_i; end
            EXE_SB_OP:  begin is_store_o = 1'b1; sel_o = w_byte_sel; wdata_o = {4{store_i[7:0]}}; end
            EXE_SH_OP:  begin is_store_o = 1'b1; sel_o = w_half_sel; wdata_o = {2{store_i[15:0]}}; end
            EXE_SW_OP:  begin is_store_o = 1'b1; sel_o = 4'b1111;    wdata_o = store_i; end
            default:    begin sel_o = 4'b0000; end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// MEM pipeline stage with a registered data-bus master. Non-memory ops pass
// straight through to the MEM/WB outputs; memory ops run IDLE -> BUSY -> DONE,
// stalling the pipeline until the bus acknowledges.
//   clk, rst (sync, active-high)
//   wd_i/wreg_i/wdata_i, hi_i/lo_i/whilo_i, aluop_i/mem_addr_i/reg2_i : EX/MEM
//   stall_i[4]           : MEM/WB hold (other bits unused here)
//   dbus_ack_i/dbus_rdata_i : bus response
//   dbus_req_o/we_o/addr_o/sel_o/wdata_o : registered bus request
//   wd_o/wreg_o/wdata_o/hi_o/lo_o/whilo_o : to MEM/WB
//   stallreq_o           : stall request to control
// Optional macro MEM_ALIGN_CHECK_EN adds misalign_o and suppresses misaligned
// halfword/word accesses.
// -----------------------------------------------------------------------------
import mem_stage_pkg::*;

module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        whilo_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [5:0]  stall_i,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_sel_o,
    output logic [31:0] dbus_wdata_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        whilo_o,
    output logic        stallreq_o
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        misalign_o
`endif
);

    mem_state_e  r_state;
    logic [31:0] r_rdata_q;
    logic        w_is_mem;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_misalign;
    logic        w_start;
    logic [3:0]  w_sel;
    logic [31:0] w_st_data;
    logic [31:0] w_ld_data;
    logic        w_unused_stall;

    assign w_unused_stall = ^{stall_i[5], stall_i[3:0]};
    assign w_is_mem       = is_mem_op(aluop_i);

`ifdef MEM_ALIGN_CHECK_EN
    // Halfword needs addr[0]=0, word needs addr[1:0]=00.
    always_comb begin
        case (aluop_i)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: w_misalign = mem_addr_i[0];
            EXE_LW_OP, EXE_SW_OP:             w_misalign = (mem_addr_i[1:0] != 2'b00);
            default:                          w_misalign = 1'b0;
        endcase
    end
    assign misalign_o = w_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    assign w_start = (r_state == ST_IDLE) && w_is_mem && !w_misalign;

    mem_lane u_lane (
        .aluop_i    (aluop_i),
        .addr_lo_i  (mem_addr_i[1:0]),
        .store_i    (reg2_i),
        .rdata_i    (r_rdata_q),
        .sel_o      (w_sel),
        .wdata_o    (w_st_data),
        .load_o     (w_ld_data),
        .is_load_o  (w_is_load),
        .is_store_o (w_is_store)
    );

    // Bus FSM: issue request, hold it until ack, park in DONE while MEM/WB holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= WRITE_DISABLE;
            dbus_addr_o  <= ZERO_WORD;
            dbus_sel_o   <= 4'b0000;
            dbus_wdata_o <= ZERO_WORD;
            r_rdata_q    <= ZERO_WORD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state      <= ST_BUSY;
                        dbus_req_o   <= 1'b1;
                        dbus_we_o    <= w_is_store;
                        dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        dbus_sel_o   <= w_sel;
                        dbus_wdata_o <= w_st_data;
                    end
                end
                ST_BUSY: begin
                    if (dbus_ack_i) begin
                        r_rdata_q  <= dbus_rdata_i;
                        dbus_req_o <= 1'b0;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!stall_i[4]) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // MEM/WB results: pass-through, or load/store result for memory ops.
    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        hi_o       = hi_i;
        lo_o       = lo_i;
        whilo_o    = whilo_i;
        stallreq_o = NO_STOP;
        if (rst) begin
            wd_o    = 5'd0;
            wreg_o  = WRITE_DISABLE;
            wdata_o = ZERO_WORD;
            hi_o    = ZERO_WORD;
            lo_o    = ZERO_WORD;
            whilo_o = WRITE_DISABLE;
        end else if (w_misalign) begin
            wreg_o = WRITE_DISABLE;
        end else if (w_is_mem) begin
            wreg_o     = w_is_load ? wreg_i : WRITE_DISABLE;
            wdata_o    = w_is_load ? w_ld_data : wdata_i;
            stallreq_o = (r_state != ST_DONE) ? STOP : NO_STOP;
        end else begin
            // A BUSY transaction always holds the pipeline, whatever EX/MEM shows.
            stallreq_o = (r_state == ST_BUSY) ? STOP : NO_STOP;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage: scoreboard bench for mem_stage. Expected bus fields and load
// results are computed by a reference model when a memory op is driven and
// compared when the DUT issues the request and reaches DONE.
// -----------------------------------------------------------------------------
import mem_stage_pkg::*;

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i, hi_i, lo_i;
    logic        whilo_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i, reg2_i;
    logic [5:0]  stall_i;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o;
    logic [3:0]  dbus_sel_o;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] bus_wdata;
        logic        we;
        logic        is_load;
        logic [31:0] result;
    } exp_t;

    exp_t sb[$];

    mem_stage dut (
        .clk(clk), .rst(rst),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
        .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .stall_i(stall_i), .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
        .stallreq_o(stallreq_o)
`ifdef MEM_ALIGN_CHECK_EN
        , .misalign_o(misalign_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: big-endian lanes, computed with shifts.
    function automatic exp_t model(input logic [7:0] op, input logic [31:0] addr,
                                   input logic [31:0] reg2, input logic [31:0] rdata);
        exp_t e;
        logic [7:0]  b;
        logic [15:0] h;
        int sh;
        sh = 8 * (3 - int'(addr[1:0]));
        b  = 8'(rdata >> sh);
        h  = addr[1] ? rdata[15:0] : rdata[31:16];
        e.addr      = addr & 32'hFFFF_FFFC;
        e.sel       = 4'b0000;
        e.bus_wdata = reg2;
        e.we        = 1'b0;
        e.is_load   = 1'b1;
        e.result    = 32'h0;
        case (op)
            EXE_LB_OP:  begin e.sel = 4'b1000 >> addr[1:0]; e.result = {{24{b[7]}}, b}; end
            EXE_LBU_OP: begin e.sel = 4'b1000 >> addr[1:0]; e.result = {24'h0, b}; end
            EXE_LH_OP:  begin e.sel = addr[1] ? 4'b0011 : 4'b1100; e.result = {{16{h[15]}}, h}; end
            EXE_LHU_OP: begin e.sel = addr[1] ? 4'b0011 : 4'b1100; e.result = {16'h0, h}; end
            EXE_LW_OP:  begin e.sel = 4'b1111; e.result = rdata; end
            EXE_SB_OP:  begin e.sel = 4'b1000 >> addr[1:0]; e.bus_wdata = {4{reg2[7:0]}}; e.we = 1'b1; e.is_load = 1'b0; end
            EXE_SH_OP:  begin e.sel = addr[1] ? 4'b0011 : 4'b1100; e.bus_wdata = {2{reg2[15:0]}}; e.we = 1'b1; e.is_load = 1'b0; end
            EXE_SW_OP:  begin e.sel = 4'b1111; e.we = 1'b1; e.is_load = 1'b0; end
            default:    begin e.is_load = 1'b0; end
        endcase
        return e;
    endfunction

    task automatic set_nop();
        aluop_i = 8'h00; wreg_i = 1'b0; wd_i = 5'd0; wdata_i = 32'h0;
        hi_i = 32'h0; lo_i = 32'h0; whilo_i = 1'b0; mem_addr_i = 32'h0; reg2_i = 32'h0;
    endtask

    // One memory transaction: ack after ack_wait BUSY cycles, DONE held hold_cycles extra.
    task automatic do_mem(input string nm, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] reg2, input logic [31:0] rdata,
                          input int ack_wait, input int hold_cycles);
        exp_t e;
        int stalls;
        logic [31:0] held;
        sb.push_back(model(op, addr, reg2, rdata));
        aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wreg_i = 1'b1; wd_i = 5'd9;
        wdata_i = 32'h5555_AAAA; dbus_rdata_i = rdata; stall_i = 6'd0; dbus_ack_i = 1'b0;
        #1;
        stalls = 0;
        if (stallreq_o) stalls++;
        total++; if (dbus_req_o !== 1'b0) begin bad++; $display("FAIL %s idle_req got=%b exp=0", nm, dbus_req_o); end
        tick();
        e = sb.pop_front();
        for (int i = 0; i <= ack_wait; i++) begin
            if (stallreq_o) stalls++;
            total++; if (dbus_req_o !== 1'b1 || dbus_we_o !== e.we || dbus_sel_o !== e.sel || dbus_addr_o !== e.addr)
                begin bad++; $display("FAIL %s bus got req=%b we=%b sel=%b addr=%h exp req=1 we=%b sel=%b addr=%h",
                    nm, dbus_req_o, dbus_we_o, dbus_sel_o, dbus_addr_o, e.we, e.sel, e.addr); end
            if (e.we) begin
                total++; if (dbus_wdata_o !== e.bus_wdata) begin bad++; $display("FAIL %s bus_wdata got=%h exp=%h", nm, dbus_wdata_o, e.bus_wdata); end
            end
            if (i == ack_wait) begin
                dbus_ack_i = 1'b1;
                stall_i[4] = (hold_cycles > 0);
            end
            tick();
        end
        dbus_ack_i = 1'b0;
        dbus_rdata_i = ~rdata;
        #1;
        total++; if (stalls != ack_wait + 2) begin bad++; $display("FAIL %s stall_cycles got=%0d exp=%0d", nm, stalls, ack_wait + 2); end
        total++; if (dbus_req_o !== 1'b0 || stallreq_o !== 1'b0 || dut.r_state !== ST_DONE)
            begin bad++; $display("FAIL %s done got req=%b stallreq=%b state=%0d exp 0/0/%0d", nm, dbus_req_o, stallreq_o, dut.r_state, ST_DONE); end
        total++; if (wreg_o !== e.is_load) begin bad++; $display("FAIL %s wreg got=%b exp=%b", nm, wreg_o, e.is_load); end
        if (e.is_load) begin
            total++; if (wdata_o !== e.result) begin bad++; $display("FAIL %s result got=%h exp=%h", nm, wdata_o, e.result); end
        end
        held = wdata_o;
        for (int k = 0; k < hold_cycles; k++) begin
            tick();
            total++; if (dut.r_state !== ST_DONE || wdata_o !== held)
                begin bad++; $display("FAIL %s hold got state=%0d wdata=%h exp state=%0d wdata=%h", nm, dut.r_state, wdata_o, ST_DONE, held); end
        end
        stall_i = 6'd0;
        tick();
        set_nop();
        #1;
        total++; if (dut.r_state !== ST_IDLE) begin bad++; $display("FAIL %s back_to_idle got=%0d exp=%0d", nm, dut.r_state, ST_IDLE); end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_i = 6'd0; dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;
        set_nop();
        aluop_i = EXE_LW_OP; wreg_i = 1'b1; wd_i = 5'd3; wdata_i = 32'h1234_5678;
        hi_i = 32'hAAAA_0000; lo_i = 32'h0000_BBBB; whilo_i = 1'b1;
        tick();
        total++; if (stallreq_o !== 1'b0 || wreg_o !== 1'b0 || wd_o !== 5'd0 || wdata_o !== 32'h0)
            begin bad++; $display("FAIL reset_outs got stall=%b wreg=%b wd=%h wdata=%h exp all 0", stallreq_o, wreg_o, wd_o, wdata_o); end
        total++; if (hi_o !== 32'h0 || lo_o !== 32'h0 || whilo_o !== 1'b0)
            begin bad++; $display("FAIL reset_hilo got hi=%h lo=%h whilo=%b exp 0", hi_o, lo_o, whilo_o); end
        total++; if (dbus_req_o !== 1'b0 || dbus_addr_o !== 32'h0 || dbus_sel_o !== 4'h0 || dut.r_state !== ST_IDLE)
            begin bad++; $display("FAIL reset_bus got req=%b addr=%h sel=%b state=%0d exp 0", dbus_req_o, dbus_addr_o, dbus_sel_o, dut.r_state); end
        set_nop();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 4; i++) begin
            aluop_i = 8'h20 + 8'(i); wd_i = 5'($urandom); wreg_i = 1'($urandom);
            wdata_i = $urandom; hi_i = $urandom; lo_i = $urandom; whilo_i = 1'($urandom);
            mem_addr_i = $urandom; dbus_ack_i = 1'b1;
            #1;
            total++; if (wd_o !== wd_i || wreg_o !== wreg_i || wdata_o !== wdata_i || hi_o !== hi_i || lo_o !== lo_i || whilo_o !== whilo_i)
                begin bad++; $display("FAIL pass_%0d got wd=%h wreg=%b wdata=%h hi=%h lo=%h whilo=%b exp %h %b %h %h %h %b", i,
                    wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, wd_i, wreg_i, wdata_i, hi_i, lo_i, whilo_i); end
            total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL pass_stall_%0d got=%b exp=0", i, stallreq_o); end
            tick();
            total++; if (dbus_req_o !== 1'b0 || dut.r_state !== ST_IDLE)
                begin bad++; $display("FAIL idle_ack_%0d got req=%b state=%0d exp 0/%0d", i, dbus_req_o, dut.r_state, ST_IDLE); end
        end
        dbus_ack_i = 1'b0;
        set_nop();
    endtask

    task automatic test_loads();
        do_mem("lw_100",  EXE_LW_OP,  32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2, 0);
        do_mem("lb_103",  EXE_LB_OP,  32'h0000_0103, 32'h0, 32'h0000_00F0, 0, 0);
        do_mem("lbu_103", EXE_LBU_OP, 32'h0000_0103, 32'h0, 32'h0000_00F0, 0, 0);
        do_mem("lb_101",  EXE_LB_OP,  32'h0000_0101, 32'h0, 32'h1281_3344, 1, 0);
        do_mem("lh_200",  EXE_LH_OP,  32'h0000_0200, 32'h0, 32'h8001_7FFF, 0, 0);
        do_mem("lhu_202", EXE_LHU_OP, 32'h0000_0202, 32'h0, 32'h1234_F00D, 0, 0);
    endtask

    task automatic test_stores();
        do_mem("sh_202", EXE_SH_OP, 32'h0000_0202, 32'h0000_1234, 32'h0, 0, 0);
        do_mem("sb_100", EXE_SB_OP, 32'h0000_0100, 32'hCAFE_BA5E, 32'h0, 1, 0);
        do_mem("sw_10c", EXE_SW_OP, 32'h0000_010C, 32'h0BAD_F00D, 32'h0, 0, 0);
    endtask

    task automatic test_stall_hold();
        do_mem("hold_lw", EXE_LW_OP, 32'h0000_0400, 32'h0, 32'h8765_4321, 0, 2);
    endtask

    task automatic test_back_to_back();
        do_mem("b2b_a", EXE_SW_OP, 32'h0000_0500, 32'h1111_2222, 32'h0, 0, 0);
        do_mem("b2b_b", EXE_LHU_OP, 32'h0000_0502, 32'h0, 32'hABCD_9876, 0, 0);
    endtask

    task automatic test_reset_abort();
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h0000_0300; wreg_i = 1'b1;
        tick();
        total++; if (dbus_req_o !== 1'b1) begin bad++; $display("FAIL abort_busy got req=%b exp=1", dbus_req_o); end
        rst = 1'b1;
        tick();
        total++; if (dbus_req_o !== 1'b0 || stallreq_o !== 1'b0 || dut.r_state !== ST_IDLE)
            begin bad++; $display("FAIL abort_rst got req=%b stall=%b state=%0d exp 0/0/%0d", dbus_req_o, stallreq_o, dut.r_state, ST_IDLE); end
        rst = 1'b0; set_nop(); dbus_ack_i = 1'b1; dbus_rdata_i = 32'hFFFF_FFFF;
        tick();
        dbus_ack_i = 1'b0;
        total++; if (dbus_req_o !== 1'b0 || dut.r_state !== ST_IDLE || dut.r_rdata_q !== 32'h0)
            begin bad++; $display("FAIL abort_late_ack got req=%b state=%0d rdata_q=%h exp 0/%0d/0", dbus_req_o, dut.r_state, dut.r_rdata_q, ST_IDLE); end
    endtask

    task automatic test_align();
`ifdef MEM_ALIGN_CHECK_EN
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h0000_0101; wreg_i = 1'b1;
        #1;
        total++; if (misalign_o !== 1'b1 || stallreq_o !== 1'b0 || wreg_o !== 1'b0)
            begin bad++; $display("FAIL misalign_lw got mis=%b stall=%b wreg=%b exp 1/0/0", misalign_o, stallreq_o, wreg_o); end
        tick();
        total++; if (dbus_req_o !== 1'b0 || dut.r_state !== ST_IDLE)
            begin bad++; $display("FAIL misalign_req got req=%b state=%0d exp 0/%0d", dbus_req_o, dut.r_state, ST_IDLE); end
        set_nop();
        tick();
`else
        do_mem("lw_101_noalign", EXE_LW_OP, 32'h0000_0101, 32'h0, 32'h0102_0304, 0, 0);
        do_mem("lh_203_noalign", EXE_LH_OP, 32'h0000_0203, 32'h0, 32'h0000_9ABC, 0, 0);
`endif
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_loads();
        test_stores();
        test_stall_hold();
        test_back_to_back();
        test_reset_abort();
        test_align();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
